alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for a shared add/sub, Booth multiply and non-restoring divide datapath.
// Optional divide-by-zero trap: define ALU_SEQ_DIV0_EN.
module alu_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        q0,
  input  logic        qminus1,
  input  logic        a_msb,
  input  logic        div_zero,
  output logic [10:0] ctrl,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  state
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD_A    = 4'd1,
    S_LOAD_B    = 4'd2,
    S_ADDSUB    = 4'd3,
    S_MUL_TEST  = 4'd4,
    S_MUL_ADD   = 4'd5,
    S_MUL_SUB   = 4'd6,
    S_MUL_SHIFT = 4'd7,
    S_DIV_SHIFT = 4'd8,
    S_DIV_ARITH = 4'd9,
    S_DIV_SETQ  = 4'd10,
    S_DIV_CORR  = 4'd11,
    S_OUT_LO    = 4'd12,
    S_OUT_HI    = 4'd13,
    S_DONE      = 4'd14,
    S_ERR       = 4'd15
  } state_t;

  state_t            cur;
  state_t            nxt;
  logic [1:0]        op_q;
  logic [CNT_W-1:0]  cnt;
  logic              sign_r;
  logic              last;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cur    <= S_IDLE;
      op_q   <= '0;
      cnt    <= '0;
      sign_r <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_IDLE && start) begin
        op_q <= op;
        cnt  <= '0;
      end
      // counter saturates on the final iteration instead of wrapping
      if (ctrl[10] && !last)
        cnt <= cnt + CNT_W'(1);
      if (cur == S_DIV_SHIFT)
        sign_r <= a_msb;
    end
  end

  always_comb begin
    nxt  = cur;
    ctrl = '0;
    unique case (cur)
      S_IDLE:      if (start) nxt = S_LOAD_A;
      S_LOAD_A: begin
        ctrl[0] = 1'b1;
        ctrl[2] = 1'b1;
        nxt     = S_LOAD_B;
      end
      S_LOAD_B: begin
        ctrl[1] = 1'b1;
        case (op_q)
          2'b10:   nxt = S_MUL_TEST;
`ifdef ALU_SEQ_DIV0_EN
          2'b11:   nxt = div_zero ? S_ERR : S_DIV_SHIFT;
`else
          2'b11:   nxt = S_DIV_SHIFT;
`endif
          default: nxt = S_ADDSUB;
        endcase
      end
      S_ADDSUB: begin
        ctrl[3] = 1'b1;
        ctrl[5] = op_q[0];
        nxt     = S_OUT_LO;
      end
      S_MUL_TEST: begin
        case ({q0, qminus1})
          2'b10:   nxt = S_MUL_SUB;
          2'b01:   nxt = S_MUL_ADD;
          default: nxt = S_MUL_SHIFT;
        endcase
      end
      S_MUL_SUB: begin
        ctrl[3] = 1'b1;
        ctrl[5] = 1'b1;
        nxt     = S_MUL_SHIFT;
      end
      S_MUL_ADD: begin
        ctrl[3] = 1'b1;
        nxt     = S_MUL_SHIFT;
      end
      S_MUL_SHIFT: begin
        ctrl[4]  = 1'b1;
        ctrl[10] = 1'b1;
        nxt      = last ? S_OUT_LO : S_MUL_TEST;
      end
      S_DIV_SHIFT: begin
        ctrl[6] = 1'b1;
        nxt     = S_DIV_ARITH;
      end
      S_DIV_ARITH: begin
        ctrl[3] = 1'b1;
        ctrl[5] = ~sign_r;
        nxt     = S_DIV_SETQ;
      end
      S_DIV_SETQ: begin
        ctrl[7]  = 1'b1;
        ctrl[10] = 1'b1;
        nxt      = last ? S_DIV_CORR : S_DIV_SHIFT;
      end
      S_DIV_CORR: begin
        ctrl[3] = a_msb;
        nxt     = S_OUT_LO;
      end
      S_OUT_LO: begin
        if (op_q[1]) begin
          ctrl[9] = 1'b1;
          nxt     = S_OUT_HI;
        end else begin
          ctrl[8] = 1'b1;
          nxt     = S_DONE;
        end
      end
      S_OUT_HI: begin
        ctrl[8] = 1'b1;
        nxt     = S_DONE;
      end
      S_DONE:      nxt = S_IDLE;
      S_ERR:       nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  assign ready = (cur == S_IDLE);
  assign busy  = ~ready;
  assign done  = (cur == S_DONE) || (cur == S_ERR);
  assign state = cur;

`ifdef ALU_SEQ_DIV0_EN
  assign err = (cur == S_ERR);
`else
  logic div_zero_unused;
  assign div_zero_unused = div_zero;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural datapath answers the control word; results are
// checked against plain arithmetic and timing rules for add, sub, Booth mul and divide.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        q0;
  logic        qminus1;
  logic        a_msb;
  logic        div_zero;
  logic [10:0] ctrl;
  logic        ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;

  alu_seq_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .q0       (q0),
    .qminus1  (qminus1),
    .a_msb    (a_msb),
    .div_zero (div_zero),
    .ctrl     (ctrl),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .state    (state)
  );

  always #5 clk = ~clk;

  // behavioural datapath: A kept as a wide signed integer so its sign is always exact
  int         dA = 0;
  int         dM = 0;
  logic [7:0] dQ = '0;
  logic       dqm1 = 1'b0;
  logic [1:0] cur_op = '0;
  int         opnd_a = 0;
  int         opnd_b = 0;

  assign q0       = dQ[0];
  assign qminus1  = dqm1;
  assign a_msb    = (dA < 0);
  assign div_zero = (opnd_b[7:0] == 8'd0);

  always @(posedge clk) begin
    if (ctrl[0]) begin
      dA   <= 0;
      dqm1 <= 1'b0;
    end
    if (ctrl[2]) dQ <= opnd_a[7:0];
    if (ctrl[1]) dM <= int'($signed(opnd_b[7:0]));
    if (ctrl[3]) begin
      if (!cur_op[1]) dA <= int'(dQ) + (ctrl[5] ? -dM : dM);
      else            dA <= ctrl[5] ? dA - dM : dA + dM;
    end
    if (ctrl[4]) begin
      dA   <= dA >>> 1;
      dQ   <= {dA[0], dQ[7:1]};
      dqm1 <= dQ[0];
    end
    if (ctrl[6]) begin
      dA <= dA * 2 + (dQ[7] ? 1 : 0);
      dQ <= {dQ[6:0], 1'b0};
    end
    if (ctrl[7]) dQ[0] <= ~a_msb;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input int a, input int b);
    @(negedge clk);
    op     = o;
    opnd_a = a;
    opnd_b = b;
    cur_op = o;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // one complete operation; poke>0 pulses start with a different op in that busy cycle
  task automatic run_op(input string tag, input logic [1:0] o, input int a, input int b,
                        input int poke);
    int         done_cyc, iter, n_out, c67, exp_done;
    logic [7:0] outs [2];
    logic       out_by_a [2];
    logic [7:0] a8, b8, sub_mask, add_mask, obs_sub, obs_add;
    logic [10:0] addsub_ctrl, ctrl_at_done;
    logic       err_at_done, prev;
    logic [15:0] prod;
    logic       div0_trap;

    a8 = a[7:0];
    b8 = b[7:0];
    sub_mask = '0; add_mask = '0; obs_sub = '0; obs_add = '0;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (a8[i] && !prev) sub_mask[i] = 1'b1;
      if (!a8[i] && prev) add_mask[i] = 1'b1;
      prev = a8[i];
    end
`ifdef ALU_SEQ_DIV0_EN
    div0_trap = (o == 2'b11) && (b8 == 8'd0);
`else
    div0_trap = 1'b0;
`endif
    case (o)
      2'b10:   exp_done = 5 + 16 + $countones(sub_mask | add_mask);
      2'b11:   exp_done = div0_trap ? 3 : 30;
      default: exp_done = 5;
    endcase

    done_cyc = -1; iter = 0; n_out = 0; c67 = 0;
    outs[0] = '0; outs[1] = '0; out_by_a[0] = 1'b0; out_by_a[1] = 1'b0;
    addsub_ctrl = '0; ctrl_at_done = '1; err_at_done = 1'b0;

    issue(o, a, b);
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == poke) begin
        start = 1'b1;
        op    = ~o;
      end else begin
        start = 1'b0;
      end
      if (state == 4'd3) addsub_ctrl = ctrl;
      if (state == 4'd6) obs_sub[iter] = 1'b1;
      if (state == 4'd5) obs_add[iter] = 1'b1;
      if (state == 4'd7) iter++;
      if (ctrl[6] || ctrl[7]) c67++;
      if ((ctrl[8] || ctrl[9]) && n_out < 2) begin
        outs[n_out]     = ctrl[8] ? dA[7:0] : dQ;
        out_by_a[n_out] = ctrl[8];
        n_out++;
      end
      if (done) begin
        done_cyc     = cyc;
        ctrl_at_done = ctrl;
        err_at_done  = err;
      end
    end
    start = 1'b0;

    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_ctrl_done"}, {21'd0, ctrl_at_done}, 32'd0);
    check({tag, "_err"}, {31'd0, err_at_done}, {31'd0, div0_trap});
    @(negedge clk);
    check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    check({tag, "_ready_after"}, {31'd0, ready}, 32'd1);

    case (o)
      2'b00, 2'b01: begin
        check({tag, "_addsub_c3"}, {31'd0, addsub_ctrl[3]}, 32'd1);
        check({tag, "_addsub_c5"}, {31'd0, addsub_ctrl[5]}, {31'd0, o[0]});
        check({tag, "_nout"}, n_out, 1);
        check({tag, "_out_on_c8"}, {31'd0, out_by_a[0]}, 32'd1);
        check({tag, "_result"}, {24'd0, outs[0]},
              {24'd0, (o[0] ? (a8 - b8) : (a8 + b8))});
      end
      2'b10: begin
        prod = 16'(a * b);
        check({tag, "_sub_iters"}, {24'd0, obs_sub}, {24'd0, sub_mask});
        check({tag, "_add_iters"}, {24'd0, obs_add}, {24'd0, add_mask});
        check({tag, "_nout"}, n_out, 2);
        check({tag, "_lo_c9"}, {31'd0, out_by_a[0]}, 32'd0);
        check({tag, "_product"}, {16'd0, outs[1], outs[0]}, {16'd0, prod});
      end
      default: begin
        if (div0_trap) begin
          check({tag, "_no_iter"}, c67, 0);
          check({tag, "_nout"}, n_out, 0);
        end else begin
          check({tag, "_c6c7"}, c67, 16);
          check({tag, "_nout"}, n_out, 2);
          if (b8 != 8'd0) begin
            check({tag, "_quot"}, {24'd0, outs[0]}, a / b);
            check({tag, "_rem"}, {24'd0, outs[1]}, a % b);
          end
        end
      end
    endcase
  endtask

  initial begin
    int ro, ra, rb;
    rst = 1'b1; start = 1'b0; op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_ctrl", {21'd0, ctrl}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_25_17", 2'b00, 25, 17, 0);
    run_op("sub_5_9", 2'b01, 5, 9, 0);
    run_op("mul_3_m7", 2'b10, 3, -7, 4);
    run_op("div_100_7", 2'b11, 100, 7, 0);
    run_op("div_by_0", 2'b11, 55, 0, 0);
    run_op("mul_m128_m128", 2'b10, -128, -128, 0);
    run_op("div_127_1", 2'b11, 127, 1, 10);

    // reset in the middle of a multiply with start also high
    issue(2'b10, 3, -7);
    repeat (9) @(negedge clk);
    check("midrun_state_before", {28'd0, state}, 32'd5);
    rst = 1'b1; start = 1'b1; op = 2'b00;
    @(posedge clk);
    #1;
    check("midrun_rst_state", {28'd0, state}, 32'd0);
    check("midrun_rst_ctrl", {21'd0, ctrl}, 32'd0);
    check("midrun_rst_ready", {31'd0, ready}, 32'd1);
    check("midrun_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("midrun_stay_idle", {28'd0, state}, 32'd0);
    run_op("post_rst_add", 2'b00, 200, 100, 0);

    for (int n = 0; n < 10; n++) begin
      ro = $urandom_range(0, 3);
      case (ro)
        2: begin ra = $urandom_range(0, 255) - 128; rb = $urandom_range(0, 255) - 128; end
        3: begin ra = $urandom_range(0, 127); rb = $urandom_range(1, 127); end
        default: begin ra = $urandom_range(0, 255); rb = $urandom_range(0, 255); end
      endcase
      run_op($sformatf("rand%0d", n), ro[1:0], ra, rb, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
